prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 153 +++++++++++++++
 tb/tb_prog_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: assembles 6-bit half-words into 12-bit words and writes a program image to memory.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing checksum word that must bring the data sum to zero.
module prog_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [5:0]  in_data,
  output logic        in_ready,
  output logic [11:0] mem_addr,
  output logic [11:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_ADDR  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_WR    = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_AFTER = S_CSUM;
`else
  localparam state_t S_AFTER = S_DONE;
`endif

  state_t      state_r, state_s;
  logic        half_r;
  logic [5:0]  hi_r;
  logic [11:0] addr_r, count_r, wdata_r;
  logic        mem_we_r, cpu_rst_r, done_r;
  logic        in_ready_s, fire_s, word_done_s;
  logic [11:0] word_s;

`ifdef LOADER_CHECKSUM_EN
  logic [11:0] csum_r;
  logic        err_r;

  function automatic logic [11:0] sum12(input logic [11:0] a, input logic [11:0] b);
    return a + b;
  endfunction
`endif

  assign fire_s      = in_valid & in_ready_s;
  assign word_s      = {hi_r, in_data};
  assign word_done_s = fire_s & half_r;

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state_r <= S_ADDR;
    else      state_r <= state_s;
  end

  // next-state logic; the write cycle decides whether more data follows
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_ADDR:  if (word_done_s) state_s = S_COUNT; else state_s = S_ADDR;
      S_COUNT: begin
        if (word_done_s) begin
          if (word_s == 12'd0) state_s = S_AFTER;
          else                 state_s = S_DATA;
        end else begin
          state_s = S_COUNT;
        end
      end
      S_DATA:  if (word_done_s) state_s = S_WR; else state_s = S_DATA;
      S_WR:    if (count_r == 12'd0) state_s = S_AFTER; else state_s = S_DATA;
      S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (word_done_s) begin
          if (sum12(csum_r, word_s) == 12'd0) state_s = S_DONE;
          else                                state_s = S_ERR;
        end else begin
          state_s = S_CSUM;
        end
`else
        state_s = S_CSUM;
`endif
      end
      S_DONE:  state_s = S_DONE;
      S_ERR:   state_s = S_ERR;
      default: state_s = S_ERR;
    endcase
  end

  // output decode: ready is gated by reset so nothing is accepted while held in reset
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      S_ADDR, S_COUNT, S_DATA, S_CSUM: in_ready_s = rst;
      default:                         in_ready_s = 1'b0;
    endcase
  end

  // word assembly, address/count tracking and registered memory/status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      half_r    <= 1'b0;
      hi_r      <= 6'd0;
      addr_r    <= 12'd0;
      count_r   <= 12'd0;
      wdata_r   <= 12'd0;
      mem_we_r  <= 1'b0;
      cpu_rst_r <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      mem_we_r <= (state_r == S_DATA) && word_done_s;
      if (fire_s) begin
        half_r <= ~half_r;
        if (!half_r) hi_r <= in_data;
      end
      if (state_r == S_ADDR && word_done_s) addr_r <= word_s;
      else if (state_r == S_WR)             addr_r <= addr_r + 12'd1;
      if (state_r == S_COUNT && word_done_s)     count_r <= word_s;
      else if (state_r == S_DATA && word_done_s) count_r <= count_r - 12'd1;
      if (state_r == S_DATA && word_done_s) wdata_r <= word_s;
      done_r    <= (state_s == S_DONE);
      cpu_rst_r <= (state_s != S_DONE);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // running sum of data words and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      csum_r <= 12'd0;
      err_r  <= 1'b0;
    end else begin
      if (state_r == S_DATA && word_done_s) csum_r <= sum12(csum_r, word_s);
      err_r <= (state_s == S_ERR);
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = in_ready_s;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_we    = mem_we_r;
  assign cpu_rst   = cpu_rst_r;
  assign done      = done_r;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: the driver queues expected writes, a monitor checks every mem_we pulse.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_data = 6'd0;
  logic        in_ready, mem_we, cpu_rst, done, err;
  logic [11:0] mem_addr, mem_wdata;

  int tests = 0;
  int fails = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_e;
  logic [11:0] data_v [0:7];

  prog_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr 0x%h data 0x%h, required no write", mem_addr, mem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp_e) begin
          fails++;
          $display("FAIL write: got addr 0x%h data 0x%h, required addr 0x%h data 0x%h",
                   mem_addr, mem_wdata, exp_e[23:12], exp_e[11:0]);
        end
      end
      check("ready_in_write", int'(in_ready), 0);
    end
  end

  task automatic send_half(input logic [5:0] h, input bit gaps);
    int budget;
    if (gaps && $urandom_range(0, 1) == 1) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = h;
    budget   = 50;
    while (in_ready !== 1'b1 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got in_ready %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] w, input bit gaps);
    send_half(w[11:6], gaps);
    send_half(w[5:0], gaps);
  endtask

  task automatic load(input logic [11:0] a, input int n, input bit gaps);
`ifdef LOADER_CHECKSUM_EN
    logic [11:0] sum;
    sum = 12'd0;
`endif
    for (int i = 0; i < n; i++) exp_q.push_back({a + 12'(i), data_v[i]});
    send_word(a, gaps);
    send_word(12'(n), gaps);
    for (int i = 0; i < n; i++) begin
      send_word(data_v[i], gaps);
`ifdef LOADER_CHECKSUM_EN
      sum = sum + data_v[i];
`endif
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(12'd0 - sum, gaps);
`endif
  endtask

  task automatic wait_done(input string tag);
    int budget;
    budget = 20;
    while (done !== 1'b1 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_cpu_rst"}, int'(cpu_rst), 0);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_wdata", int'(mem_wdata), 0);
    check("rst_cpu_rst", int'(cpu_rst), 1);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b1;
    #1;
    check("rst_release_ready", int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] w;

    do_reset();
    data_v[0] = 12'h123; data_v[1] = 12'h456; data_v[2] = 12'h789;
    load(12'h010, 3, 1'b0);
    wait_done("basic");

    do_reset();
    data_v[0] = 12'hAAA; data_v[1] = 12'h555;
    load(12'hFFF, 2, 1'b0);
    wait_done("wrap");

    do_reset();
    load(12'h200, 0, 1'b0);
    wait_done("count0");

    do_reset();
    data_v[0] = 12'h123; data_v[1] = 12'h456; data_v[2] = 12'h789;
    load(12'h010, 3, 1'b1);
    wait_done("gaps");

    // abort mid-load, after the high half of the second data word
    do_reset();
    exp_q.push_back({12'h100, 12'h111});
    send_word(12'h100, 1'b0);
    send_word(12'h003, 1'b0);
    send_word(12'h111, 1'b0);
    w = 12'h222;
    send_half(w[11:6], 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_mem_we", int'(mem_we), 0);
    check("abort_pending_writes", exp_q.size(), 0);
    check("abort_done", int'(done), 0);
    check("abort_cpu_rst", int'(cpu_rst), 1);
    rst = 1'b1;
    #1;
    check("abort_release_ready", int'(in_ready), 1);
    load(12'h010, 3, 1'b0);
    wait_done("reload");

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    exp_q.push_back({12'h020, 12'h001});
    exp_q.push_back({12'h021, 12'h002});
    send_word(12'h020, 1'b0);
    send_word(12'h002, 1'b0);
    send_word(12'h001, 1'b0);
    send_word(12'h002, 1'b0);
    send_word(12'hFFD, 1'b0);
    wait_done("csum_good");

    do_reset();
    exp_q.push_back({12'h020, 12'h001});
    exp_q.push_back({12'h021, 12'h002});
    send_word(12'h020, 1'b0);
    send_word(12'h002, 1'b0);
    send_word(12'h001, 1'b0);
    send_word(12'h002, 1'b0);
    send_word(12'hFFC, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("csum_bad_err", int'(err), 1);
    check("csum_bad_cpu_rst", int'(cpu_rst), 1);
    check("csum_bad_in_ready", int'(in_ready), 0);
    check("csum_bad_done", int'(done), 0);
    check("csum_bad_pending", exp_q.size(), 0);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
